// File: rtl/branch_resolver_if.sv
// Fetch/execute-facing signal bundle of the branch resolver.
// The master side records predictions and resolves branches; the slave side is the resolver.
interface branch_resolver_if;
  logic        push_valid;
  logic        push_taken;
  logic [15:0] push_target;
  logic [15:0] push_fallthru;
  logic [15:0] push_psw;
  logic        full;
  logic        empty;
  logic        res_valid;
  logic        res_taken;
  logic [15:0] res_target;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        psw_restore_valid;
  logic [15:0] psw_restore;
  logic        flush;
  logic [15:0] branch_count;
  logic [15:0] mispredict_count;
  logic        err_overflow;
  logic        err_underflow;

  modport master (
    output push_valid, push_taken, push_target, push_fallthru, push_psw,
    output res_valid, res_taken, res_target,
    input  full, empty, redirect_valid, redirect_pc, psw_restore_valid, psw_restore,
    input  flush, branch_count, mispredict_count, err_overflow, err_underflow
  );

  modport slave (
    input  push_valid, push_taken, push_target, push_fallthru, push_psw,
    input  res_valid, res_taken, res_target,
    output full, empty, redirect_valid, redirect_pc, psw_restore_valid, psw_restore,
    output flush, branch_count, mispredict_count, err_overflow, err_underflow
  );
endinterface

// File: rtl/branch_resolver.sv
// Execute-stage branch resolver: queues fetch predictions, checks them against
// actual outcomes, and issues a redirect plus a timed pipeline flush on a mispredict.
module branch_resolver #(
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input logic              clk,
  input logic              rst_n,
  branch_resolver_if.slave br
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);
  localparam logic [CW-1:0] FLUSH_INIT = CW'(FLUSH_CYCLES);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_FLUSH = 1'b1} state_t;

  state_t          state_r;
  logic [CW-1:0]   flush_cnt_r;
  logic [48:0]     mem_r [DEPTH];
  logic [PW:0]     wr_ptr_r, rd_ptr_r;
  logic            full_r, empty_r, flush_r, redirect_valid_r;
  logic [15:0]     redirect_pc_r, psw_restore_r;
  logic [15:0]     branch_count_r, mispredict_count_r;
  logic            err_overflow_r, err_underflow_r;

  logic [48:0]     head_s;
  logic            res_do_s, mispredict_s, pop_s, push_do_s;
  logic            overflow_set_s, underflow_set_s;
  logic [PW:0]     wr_ptr_nxt_s, rd_ptr_nxt_s;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : (v + 16'd1);
  endfunction

  assign head_s = mem_r[rd_ptr_r[PW-1:0]];

  // Resolve/push arbitration and next queue pointers.
  always_comb begin
    res_do_s        = br.res_valid && (state_r == ST_IDLE) && !empty_r;
    mispredict_s    = res_do_s && ((br.res_taken != head_s[48]) ||
                      (br.res_taken && (br.res_target != head_s[47:32])));
    pop_s           = res_do_s && !mispredict_s;
    // A same-cycle pop frees a slot, so a push into a full queue is legal then.
    push_do_s       = br.push_valid && (state_r == ST_IDLE) && !mispredict_s && (!full_r || pop_s);
    overflow_set_s  = br.push_valid && (state_r == ST_IDLE) && full_r && !res_do_s;
    underflow_set_s = br.res_valid && (state_r == ST_IDLE) && empty_r;
    wr_ptr_nxt_s    = wr_ptr_r;
    rd_ptr_nxt_s    = rd_ptr_r;
    if (mispredict_s) begin
      rd_ptr_nxt_s = wr_ptr_r;
    end else begin
      wr_ptr_nxt_s = wr_ptr_r + {{PW{1'b0}}, push_do_s};
      rd_ptr_nxt_s = rd_ptr_r + {{PW{1'b0}}, pop_s};
    end
  end

  // Prediction queue storage, pointers and registered occupancy flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= 49'd0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (push_do_s) begin
        mem_r[wr_ptr_r[PW-1:0]] <= {br.push_taken, br.push_target, br.push_fallthru, br.push_psw};
      end
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      full_r   <= (wr_ptr_nxt_s[PW] != rd_ptr_nxt_s[PW]) &&
                  (wr_ptr_nxt_s[PW-1:0] == rd_ptr_nxt_s[PW-1:0]);
      empty_r  <= (wr_ptr_nxt_s == rd_ptr_nxt_s);
    end
  end

  // Flush FSM, redirect outputs, statistics and sticky errors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r            <= ST_IDLE;
      flush_cnt_r        <= '0;
      flush_r            <= 1'b0;
      redirect_valid_r   <= 1'b0;
      redirect_pc_r      <= 16'd0;
      psw_restore_r      <= 16'd0;
      branch_count_r     <= 16'd0;
      mispredict_count_r <= 16'd0;
      err_overflow_r     <= 1'b0;
      err_underflow_r    <= 1'b0;
    end else begin
      redirect_valid_r <= mispredict_s;
      case (state_r)
        ST_IDLE: begin
          if (mispredict_s) begin
            state_r       <= ST_FLUSH;
            flush_cnt_r   <= FLUSH_INIT;
            flush_r       <= 1'b1;
            redirect_pc_r <= br.res_taken ? br.res_target : head_s[31:16];
            psw_restore_r <= head_s[15:0];
          end else begin
            flush_r <= 1'b0;
          end
        end
        ST_FLUSH: begin
          if (flush_cnt_r == CW'(1)) begin
            state_r <= ST_IDLE;
            flush_r <= 1'b0;
          end else begin
            flush_cnt_r <= flush_cnt_r - CW'(1);
            flush_r     <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          flush_r <= 1'b0;
        end
      endcase
      if (res_do_s) branch_count_r <= sat_inc(branch_count_r);
      if (mispredict_s) mispredict_count_r <= sat_inc(mispredict_count_r);
      if (overflow_set_s) err_overflow_r <= 1'b1;
      if (underflow_set_s) err_underflow_r <= 1'b1;
    end
  end

  assign br.full              = full_r;
  assign br.empty             = empty_r;
  assign br.flush             = flush_r;
  assign br.redirect_valid    = redirect_valid_r;
  assign br.psw_restore_valid = redirect_valid_r;
  assign br.redirect_pc       = redirect_pc_r;
  assign br.psw_restore       = psw_restore_r;
  assign br.branch_count      = branch_count_r;
  assign br.mispredict_count  = mispredict_count_r;
  assign br.err_overflow      = err_overflow_r;
  assign br.err_underflow     = err_underflow_r;
endmodule
